// File: rtl/uart_receiver.sv
`default_nettype none
// ============================================================================
// Module      : uart_receiver
// Description : Oversampled UART receive path (start, data LSB-first, parity,
//               stop) with per-frame parity/framing flags and valid strobe.
// Revision    : 1.0 - initial release
// ============================================================================

module uart_receiver #(
  parameter int OVERSAMPLE = 16,
  parameter int DATA_BITS  = 8,
  parameter int PARITY_ODD = 0
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 sample_tick,
  input  logic                 rx,
  output logic [DATA_BITS-1:0] data_out,
  output logic                 data_valid,
  output logic                 parity_error,
  output logic                 framing_error,
  output logic                 busy
);

  localparam int                 c_TICK_W    = $clog2(OVERSAMPLE);
  localparam int                 c_BIT_W     = $clog2(DATA_BITS + 1);
  localparam logic [c_TICK_W-1:0] c_TICK_MID  = c_TICK_W'(OVERSAMPLE / 2 - 1);
  localparam logic [c_TICK_W-1:0] c_TICK_LAST = c_TICK_W'(OVERSAMPLE - 1);
  localparam logic [c_BIT_W-1:0]  c_BIT_LAST  = c_BIT_W'(DATA_BITS - 1);
  localparam logic                c_ODD       = (PARITY_ODD != 0);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_START  = 3'd1,
    S_DATA   = 3'd2,
    S_PARITY = 3'd3,
    S_STOP   = 3'd4,
    S_BREAK  = 3'd5
  } state_t;

  state_t                r_state;
  logic                  r_rx_meta;
  logic                  r_rx_s;
  logic [c_TICK_W-1:0]   r_tick_cnt;
  logic [c_BIT_W-1:0]    r_bit_cnt;
  logic [DATA_BITS-1:0]  r_shift;
  logic                  r_par_err;
  logic                  w_sample;

  // Full-period sample point; tick counter wraps here so the next bit lines up.
  assign w_sample = sample_tick && (r_tick_cnt == c_TICK_LAST);

  always_ff @(posedge clock) begin
    if (reset) begin
      r_state       <= S_IDLE;
      r_rx_meta     <= 1'b1;
      r_rx_s        <= 1'b1;
      r_tick_cnt    <= '0;
      r_bit_cnt     <= '0;
      r_shift       <= '0;
      r_par_err     <= 1'b0;
      data_out      <= '0;
      data_valid    <= 1'b0;
      parity_error  <= 1'b0;
      framing_error <= 1'b0;
      busy          <= 1'b0;
    end else begin
      r_rx_meta  <= rx;
      r_rx_s     <= r_rx_meta;
      data_valid <= 1'b0;

      case (r_state)
        S_IDLE: begin
          r_tick_cnt <= '0;
          if (!r_rx_s) begin
            r_state <= S_START;
            busy    <= 1'b1;
          end
        end

        S_START: begin
          if (sample_tick) begin
            if (r_tick_cnt == c_TICK_MID) begin
              r_tick_cnt <= '0;
              r_bit_cnt  <= '0;
              if (r_rx_s) begin
                r_state <= S_IDLE;
                busy    <= 1'b0;
              end else begin
                r_state <= S_DATA;
              end
            end else begin
              r_tick_cnt <= r_tick_cnt + 1'b1;
            end
          end
        end

        S_DATA: begin
          if (sample_tick) begin
            r_tick_cnt <= r_tick_cnt + 1'b1;
          end
          if (w_sample) begin
            r_shift   <= {r_rx_s, r_shift[DATA_BITS-1:1]};
            r_bit_cnt <= r_bit_cnt + 1'b1;
            if (r_bit_cnt == c_BIT_LAST) begin
              r_state <= S_PARITY;
            end
          end
        end

        S_PARITY: begin
          if (sample_tick) begin
            r_tick_cnt <= r_tick_cnt + 1'b1;
          end
          if (w_sample) begin
            r_par_err <= (^r_shift) ^ r_rx_s ^ c_ODD;
            r_state   <= S_STOP;
          end
        end

        S_STOP: begin
          if (sample_tick) begin
            r_tick_cnt <= r_tick_cnt + 1'b1;
          end
          if (w_sample) begin
            data_out      <= r_shift;
            parity_error  <= r_par_err;
            framing_error <= ~r_rx_s;
            data_valid    <= 1'b1;
            if (r_rx_s) begin
              r_state <= S_IDLE;
              busy    <= 1'b0;
            end else begin
              r_state <= S_BREAK;
            end
          end
        end

        // Line held low past the stop bit: swallow it until it idles again.
        S_BREAK: begin
          if (r_rx_s) begin
            r_state <= S_IDLE;
            busy    <= 1'b0;
          end
        end

        default: begin
          r_state <= S_IDLE;
          busy    <= 1'b0;
        end
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_uart_receiver.sv
`default_nettype none
// Testbench for uart_receiver: table vectors, hand-written corner sequences
// and randomized frames scored against a frame-level reference model.

module tb_uart_receiver;

  localparam int OS       = 16;
  localparam int TICK_DIV = 4;
  localparam int BIT_CLKS = OS * TICK_DIV;
  localparam int LAT_NOM  = (21 * BIT_CLKS) / 2 + 3;

  logic       clock = 1'b0;
  logic       reset;
  logic       sample_tick;
  logic       rx;
  logic [7:0] data_out;
  logic       data_valid;
  logic       parity_error;
  logic       framing_error;
  logic       busy;

  int checks  = 0;
  int errors  = 0;
  int cyc     = 0;
  int strobes = 0;
  int start_cyc = 0;

  logic [7:0] last_data;
  logic       last_perr;
  logic       last_ferr;
  logic       prev_valid = 1'b0;

  typedef struct packed {
    logic [7:0] data;
    logic       perr;
    logic       ferr;
  } exp_t;

  exp_t exp_q[$];

  typedef struct {
    logic [7:0] data;
    logic       par_flip;
    logic       stop;
    int         low_bits;
    logic [7:0] exp_data;
    logic       exp_perr;
    logic       exp_ferr;
  } vec_t;

  vec_t vecs[6];

  uart_receiver #(
    .OVERSAMPLE(OS),
    .DATA_BITS (8),
    .PARITY_ODD(0)
  ) dut (
    .clock        (clock),
    .reset        (reset),
    .sample_tick  (sample_tick),
    .rx           (rx),
    .data_out     (data_out),
    .data_valid   (data_valid),
    .parity_error (parity_error),
    .framing_error(framing_error),
    .busy         (busy)
  );

  always #5 clock = ~clock;

  always @(posedge clock) cyc <= cyc + 1;

  initial begin
    sample_tick = 1'b0;
    forever begin
      repeat (TICK_DIV - 1) @(posedge clock);
      #1 sample_tick = 1'b1;
      @(posedge clock);
      #1 sample_tick = 1'b0;
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: actual %0h required %0h", name, act, req);
    end
  endtask

  // Scoreboard: each strobe must match the oldest expected frame.
  always @(negedge clock) begin
    if (data_valid) begin
      int lat;
      exp_t e;
      strobes++;
      last_data = data_out;
      last_perr = parity_error;
      last_ferr = framing_error;
      check("valid_not_consecutive", {31'd0, prev_valid}, 32'd0);
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_strobe: actual data %0h required no strobe", data_out);
      end else begin
        e = exp_q.pop_front();
        check("sb_data", {24'd0, data_out}, {24'd0, e.data});
        check("sb_parity_error", {31'd0, parity_error}, {31'd0, e.perr});
        check("sb_framing_error", {31'd0, framing_error}, {31'd0, e.ferr});
        check("sb_busy_at_strobe", {31'd0, busy}, {31'd0, e.ferr});
        lat = cyc - start_cyc;
        check("sb_latency_window", {31'd0, (lat >= LAT_NOM - 8) && (lat <= LAT_NOM + 8)}, 32'd1);
      end
    end
    prev_valid = data_valid;
  end

  task automatic tick_clks(input int n);
    repeat (n) @(posedge clock);
    #1;
  endtask

  task automatic send_bit(input logic b);
    rx = b;
    tick_clks(BIT_CLKS);
  endtask

  // Reference model: expected byte and flags follow directly from the bits sent.
  task automatic send_frame(input logic [7:0] data, input logic par_flip, input logic stop);
    logic p;
    exp_t e;
    p = (^data) ^ par_flip;
    e.data = data;
    e.perr = (^data) ^ p ^ 1'b0;
    e.ferr = ~stop;
    exp_q.push_back(e);
    start_cyc = cyc;
    send_bit(1'b0);
    for (int i = 0; i < 8; i++) send_bit(data[i]);
    send_bit(p);
    send_bit(stop);
  endtask

  initial begin
    #3_000_000;
    $display("FAIL watchdog: actual timeout required completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int s0;
    int wait_cnt;

    vecs[0] = '{8'h55, 1'b0, 1'b1, 0, 8'h55, 1'b0, 1'b0};
    vecs[1] = '{8'h80, 1'b1, 1'b1, 0, 8'h80, 1'b1, 1'b0};
    vecs[2] = '{8'h01, 1'b0, 1'b1, 0, 8'h01, 1'b0, 1'b0};
    vecs[3] = '{8'hA3, 1'b0, 1'b0, 2, 8'hA3, 1'b0, 1'b1};
    vecs[4] = '{8'h00, 1'b0, 1'b1, 0, 8'h00, 1'b0, 1'b0};
    vecs[5] = '{8'hFF, 1'b1, 1'b1, 0, 8'hFF, 1'b1, 1'b0};

    reset = 1'b1;
    rx    = 1'b1;
    tick_clks(3);
    check("reset_data_out", {24'd0, data_out}, 32'd0);
    check("reset_data_valid", {31'd0, data_valid}, 32'd0);
    check("reset_parity_error", {31'd0, parity_error}, 32'd0);
    check("reset_framing_error", {31'd0, framing_error}, 32'd0);
    check("reset_busy", {31'd0, busy}, 32'd0);
    reset = 1'b0;
    tick_clks(BIT_CLKS);

    foreach (vecs[k]) begin
      s0 = strobes;
      send_frame(vecs[k].data, vecs[k].par_flip, vecs[k].stop);
      if (!vecs[k].stop) begin
        tick_clks(vecs[k].low_bits * BIT_CLKS);
        check("vec_busy_in_break", {31'd0, busy}, 32'd1);
        rx = 1'b1;
      end
      tick_clks(BIT_CLKS);
      check("vec_strobe_count", s0 == strobes ? 32'd0 : strobes - s0, 32'd1);
      check("vec_data_out", {24'd0, last_data}, {24'd0, vecs[k].exp_data});
      check("vec_parity_error", {31'd0, last_perr}, {31'd0, vecs[k].exp_perr});
      check("vec_framing_error", {31'd0, last_ferr}, {31'd0, vecs[k].exp_ferr});
      check("vec_busy_idle", {31'd0, busy}, 32'd0);
    end

    // Glitch shorter than half a bit: false start, no strobe.
    s0 = strobes;
    rx = 1'b0;
    tick_clks(4 * TICK_DIV);
    check("glitch_busy_high", {31'd0, busy}, 32'd1);
    rx = 1'b1;
    wait_cnt = 0;
    while (busy && wait_cnt < 3 * BIT_CLKS) begin
      tick_clks(1);
      wait_cnt++;
    end
    check("glitch_back_to_idle", {31'd0, busy}, 32'd0);
    tick_clks(BIT_CLKS);
    check("glitch_no_strobe", strobes - s0, 32'd0);

    // Back-to-back frames, no idle gap.
    s0 = strobes;
    send_frame(8'h12, 1'b0, 1'b1);
    send_frame(8'h34, 1'b0, 1'b1);
    tick_clks(BIT_CLKS);
    check("b2b_strobe_count", strobes - s0, 32'd2);
    check("b2b_last_data", {24'd0, last_data}, 32'h34);

    // Reset during data bit 4 of 0xFF.
    s0 = strobes;
    send_bit(1'b0);
    for (int i = 0; i < 4; i++) send_bit(1'b1);
    tick_clks(BIT_CLKS / 2);
    reset = 1'b1;
    tick_clks(3);
    rx = 1'b1;
    check("midreset_data_out", {24'd0, data_out}, 32'd0);
    check("midreset_data_valid", {31'd0, data_valid}, 32'd0);
    check("midreset_parity_error", {31'd0, parity_error}, 32'd0);
    check("midreset_framing_error", {31'd0, framing_error}, 32'd0);
    check("midreset_busy", {31'd0, busy}, 32'd0);
    reset = 1'b0;
    tick_clks(2 * BIT_CLKS);
    check("midreset_no_strobe", strobes - s0, 32'd0);
    send_frame(8'h3C, 1'b0, 1'b1);
    tick_clks(BIT_CLKS);
    check("midreset_next_count", strobes - s0, 32'd1);
    check("midreset_next_data", {24'd0, last_data}, 32'h3C);

    // Randomized frames with random parity corruption, breaks and gaps.
    for (int n = 0; n < 20; n++) begin
      logic [7:0] d;
      logic       flip;
      logic       stop;
      int         gap;
      d    = 8'($urandom);
      flip = ($urandom_range(0, 3) == 0);
      stop = ($urandom_range(0, 7) != 0);
      gap  = $urandom_range(0, 2);
      send_frame(d, flip, stop);
      if (!stop) begin
        tick_clks(BIT_CLKS);
        rx = 1'b1;
        if (gap == 0) gap = 1;
      end
      rx = 1'b1;
      tick_clks(gap * BIT_CLKS);
    end

    tick_clks(2 * BIT_CLKS);
    check("scoreboard_drained", exp_q.size(), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
